// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO output path.
// Optional feature macro: APB_GPIO_EXT_STROBE_EN.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } out_state_t;

  localparam int GPIO_W = 32;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop synchronizer plus history flop with rise/fall pulses.
// Used by aux_out_if only when APB_GPIO_EXT_STROBE_EN is defined.
module gpio_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync;
  logic         hist;

  // shift the async input through the sync chain, keep one history bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], d};
      hist <= sync[N-1];
    end
  end

  assign rise = sync[N-1] & ~hist;
  assign fall = ~sync[N-1] & hist;

endmodule

// File: rtl/aux_out_if.sv
// Double-buffered GPIO output stage with atomic commit and aux routing.
// Macro APB_GPIO_EXT_STROBE_EN enables the external strobe commit path.
module aux_out_if
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             stage_wr,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] oe_data,
  input  logic [WIDTH-1:0] aux_sel,
  input  logic [WIDTH-1:0] aux_i,
  input  logic             ext_mode,
  input  logic             strb_neg,
  input  logic             ext_strb,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oen,
  output logic             pending,
  output logic             commit_ack
);

  out_state_t       state;
  logic [WIDTH-1:0] shadow_out;
  logic [WIDTH-1:0] shadow_oe;
  logic [WIDTH-1:0] shadow_sel;
  logic [WIDTH-1:0] active_out;
  logic [WIDTH-1:0] active_sel;
  logic [WIDTH-1:0] commit_mux;
  logic [WIDTH-1:0] hold_mux;
  logic             strb_edge;
  logic             ext_en;

`ifdef APB_GPIO_EXT_STROBE_EN
  logic strb_rise;
  logic strb_fall;

  gpio_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_strb (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (ext_strb),
    .rise(strb_rise),
    .fall(strb_fall)
  );

  assign strb_edge = strb_neg ? strb_fall : strb_rise;
  assign ext_en    = ext_mode;
`else
  localparam int UNUSED_STAGES = SYNC_STAGES;
  logic unused_strb;

  assign unused_strb = ^{ext_mode, strb_neg, ext_strb};
  assign strb_edge   = 1'b0;
  assign ext_en      = 1'b0;
`endif

  assign commit_mux = (shadow_sel & aux_i) | (~shadow_sel & shadow_out);
  assign hold_mux   = (active_sel & aux_i) | (~active_sel & active_out);
  assign pending    = (state != IDLE);

  // staging, commit FSM and registered pad outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      shadow_out <= '0;
      shadow_oe  <= '0;
      shadow_sel <= '0;
      active_out <= '0;
      active_sel <= '0;
      gpio_out   <= '0;
      gpio_oen   <= '1;
      commit_ack <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      if (state == COMMIT) begin
        active_out <= shadow_out;
        active_sel <= shadow_sel;
        gpio_oen   <= ~shadow_oe;
        gpio_out   <= commit_mux;
        commit_ack <= 1'b1;
      end else begin
        gpio_out <= hold_mux;
      end
      if (stage_wr) begin
        shadow_out <= out_data;
        shadow_oe  <= oe_data;
        shadow_sel <= aux_sel;
        state      <= PENDING;
      end else begin
        unique case (state)
          IDLE:    state <= IDLE;
          PENDING: if (!ext_en || strb_edge) state <= COMMIT;
          COMMIT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aux_out_if.sv
// Directed self-checking bench for aux_out_if.
// Strobe scenarios run when APB_GPIO_EXT_STROBE_EN is defined.
module tb_aux_out_if;

  localparam int W = 32;

  logic         sys_clk  = 1'b0;
  logic         sys_rst  = 1'b0;
  logic         stage_wr = 1'b0;
  logic [W-1:0] out_data = '0;
  logic [W-1:0] oe_data  = '0;
  logic [W-1:0] aux_sel  = '0;
  logic [W-1:0] aux_i    = '0;
  logic         ext_mode = 1'b0;
  logic         strb_neg = 1'b0;
  logic         ext_strb = 1'b0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oen;
  logic         pending;
  logic         commit_ack;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  aux_out_if #(
    .WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .stage_wr  (stage_wr),
    .out_data  (out_data),
    .oe_data   (oe_data),
    .aux_sel   (aux_sel),
    .aux_i     (aux_i),
    .ext_mode  (ext_mode),
    .strb_neg  (strb_neg),
    .ext_strb  (ext_strb),
    .gpio_out  (gpio_out),
    .gpio_oen  (gpio_oen),
    .pending   (pending),
    .commit_ack(commit_ack)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic stage(input logic [W-1:0] o,
                       input logic [W-1:0] e,
                       input logic [W-1:0] s);
    out_data = o;
    oe_data  = e;
    aux_sel  = s;
    stage_wr = 1'b1;
    tick();
    stage_wr = 1'b0;
  endtask

  initial begin
    // 1: async reset mid-cycle, no clock edge in between
    #12;
    sys_rst = 1'b1;
    #1;
    check("rst_out", gpio_out, 32'h0);
    check("rst_oen", gpio_oen, 32'hFFFF_FFFF);
    check("rst_pend", {31'b0, pending}, 32'h0);
    check("rst_ack", {31'b0, commit_ack}, 32'h0);
    tick();
    sys_rst = 1'b0;
    tick();

    // 2: immediate commit, pads update at k+2
    stage(32'd125, 32'hFFFF_FFFF, 32'h0);
    check("imm_pend_k", {31'b0, pending}, 32'h1);
    check("imm_out_k", gpio_out, 32'h0);
    tick();
    check("imm_ack_k1", {31'b0, commit_ack}, 32'h0);
    check("imm_oen_k1", gpio_oen, 32'hFFFF_FFFF);
    tick();
    check("imm_out_k2", gpio_out, 32'd125);
    check("imm_oen_k2", gpio_oen, 32'h0);
    check("imm_ack_k2", {31'b0, commit_ack}, 32'h1);
    check("imm_pend_k2", {31'b0, pending}, 32'h0);
    tick();
    check("imm_ack_k3", {31'b0, commit_ack}, 32'h0);
    check("imm_hold", gpio_out, 32'd125);

    // 3: aux routing on low byte, upper aux bits must not leak
    stage(32'h0, 32'hFFFF_FFFF, 32'h0000_00FF);
    tick();
    tick();
    check("aux_commit", gpio_out, 32'h0);
    aux_i = 32'hABCD_EFC6;
    #1;
    check("aux_noedge", gpio_out, 32'h0);
    tick();
    check("aux_follow", gpio_out, 32'h0000_00C6);
    aux_i = 32'h0000_0001;
    tick();
    check("aux_follow2", gpio_out, 32'h0000_0001);
    aux_i = '0;
    tick();

`ifdef APB_GPIO_EXT_STROBE_EN
    // 4: strobe commit, pads update at e4
    ext_mode = 1'b1;
    stage(32'd134, 32'hFFFF_FFFF, 32'h0);
    tick();
    tick();
    check("stb_wait_pend", {31'b0, pending}, 32'h1);
    check("stb_wait_out", gpio_out, 32'h0);
    ext_strb = 1'b1;
    tick();
    tick();
    tick();
    check("stb_e3_pend", {31'b0, pending}, 32'h1);
    check("stb_e3_out", gpio_out, 32'h0);
    check("stb_e3_ack", {31'b0, commit_ack}, 32'h0);
    tick();
    check("stb_e4_out", gpio_out, 32'd134);
    check("stb_e4_ack", {31'b0, commit_ack}, 32'h1);
    check("stb_e4_pend", {31'b0, pending}, 32'h0);

    // 5: stage_wr collides with a detected strobe edge
    ext_strb = 1'b0;
    stage(32'd50, 32'hFFFF_FFFF, 32'h0);
    tick();
    tick();
    tick();
    check("col_fall_ign", gpio_out, 32'd134);
    check("col_fall_pend", {31'b0, pending}, 32'h1);
    ext_strb = 1'b1;
    tick();
    tick();
    stage(32'd7, 32'hFFFF_FFFF, 32'h0);
    check("col_noack", {31'b0, commit_ack}, 32'h0);
    tick();
    tick();
    check("col_out", gpio_out, 32'd134);
    check("col_pend", {31'b0, pending}, 32'h1);
    ext_strb = 1'b0;
    repeat (4) tick();
    ext_strb = 1'b1;
    tick();
    tick();
    tick();
    check("col_e3_out", gpio_out, 32'd134);
    tick();
    check("col_e4_out", gpio_out, 32'd7);
    check("col_e4_ack", {31'b0, commit_ack}, 32'h1);

    // 6: reset while pending discards the staged set
    stage(32'd99, 32'hFFFF_FFFF, 32'h0);
    check("rmid_pend", {31'b0, pending}, 32'h1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("rmid_out", gpio_out, 32'h0);
    check("rmid_oen", gpio_oen, 32'hFFFF_FFFF);
    check("rmid_pend0", {31'b0, pending}, 32'h0);
    tick();
    sys_rst = 1'b0;
    repeat (4) tick();
    ext_strb = 1'b0;
    repeat (3) tick();
    ext_strb = 1'b1;
    repeat (5) tick();
    check("rpost_pend", {31'b0, pending}, 32'h0);
    check("rpost_out", gpio_out, 32'h0);
    check("rpost_oen", gpio_oen, 32'hFFFF_FFFF);
`else
    // without the strobe feature ext_mode is ignored
    ext_mode = 1'b1;
    ext_strb = 1'b1;
    stage(32'd134, 32'hFFFF_FFFF, 32'h0);
    tick();
    check("nostb_k1_out", gpio_out, 32'h0);
    tick();
    check("nostb_k2_out", gpio_out, 32'd134);
    check("nostb_k2_ack", {31'b0, commit_ack}, 32'h1);
    check("nostb_pend", {31'b0, pending}, 32'h0);
    stage(32'd99, 32'h0000_FFFF, 32'h0);
    #2;
    sys_rst = 1'b1;
    #1;
    check("rmid_out", gpio_out, 32'h0);
    check("rmid_oen", gpio_oen, 32'hFFFF_FFFF);
    check("rmid_pend0", {31'b0, pending}, 32'h0);
    tick();
    sys_rst = 1'b0;
    repeat (4) tick();
    check("rpost_out", gpio_out, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
